// File: rtl/arbitro_pkg.sv
// Shared definitions for the account ledger arbiter: state encoding, operation
// type codes and status flag positions.
package arbitro_pkg;

  // One-hot FSM encoding
  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StLatch = 4'b0010,
    StExec  = 4'b0100,
    StDone  = 4'b1000
  } estado_e;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  // Bit positions inside the status flag vector
  localparam int unsigned FLAG_OK       = 0;
  localparam int unsigned FLAG_FONDOS   = 1;
  localparam int unsigned FLAG_DESBORDE = 2;
  localparam int unsigned FLAG_RECHAZO  = 3;
  localparam int unsigned NUM_FLAGS     = 4;

  // Index of the set bit in a one-hot vector of up to 8 requesters
  function automatic logic [2:0] oh_a_indice(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin selector: scans requests starting at ptr_i and
// returns the first active one as a one-hot vector.
module arbitro_rr #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o
);

  logic        encontrado;
  int unsigned idx;

  // Walk the requesters in circular order from the pointer; first hit wins
  always_comb begin
    gnt_o      = '0;
    encontrado = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr_i) + i) % N_REQ;
      if (!encontrado && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        encontrado = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_balance.sv
// Shared-account ledger controller. Serialises read-modify-write operations on
// the balance register between N_REQ requesters with round-robin fairness.
// Every output is registered; each transaction spends one cycle in each of
// LATCH, EXEC and DONE, followed by at least one IDLE cycle.
module arbitro_balance
  import arbitro_pkg::*;
#(
  parameter int unsigned      N_REQ    = 3,
  parameter int unsigned      BAL_W    = 32,
  parameter int unsigned      MONTO_W  = 32,
  parameter logic [BAL_W-1:0] BAL_INIT = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0]           tipo_i,
  input  logic [N_REQ*MONTO_W-1:0]   monto_i,
  input  logic                       bloqueo_in_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       ok_o,
  output logic                       fondos_insuficientes_o,
  output logic                       desborde_o,
  output logic                       rechazado_o,
  output logic [BAL_W-1:0]           balance_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  estado_e                state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       win_q, win_d;
  logic                   tipo_q, tipo_d;
  logic [BAL_W-1:0]       monto_q, monto_d;
  logic [BAL_W-1:0]       balance_q, balance_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;

  logic [N_REQ-1:0]       rr_gnt;
  logic [7:0]             rr_gnt_ext;
  logic [2:0]             rr_idx;
  logic [MONTO_W-1:0]     monto_sel;
  logic [BAL_W:0]         suma;

  arbitro_rr #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  assign rr_gnt_ext = 8'(rr_gnt);
  assign rr_idx     = oh_a_indice(rr_gnt_ext);
  assign monto_sel  = monto_i[MONTO_W*int'(win_q) +: MONTO_W];
  // One extra bit so a deposit carry-out is visible
  assign suma       = {1'b0, balance_q} + {1'b0, monto_q};

  // Next-state, operand capture, balance update and registered output values
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    tipo_d    = tipo_q;
    monto_d   = monto_q;
    balance_d = balance_q;
    gnt_d     = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    flags_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StLatch;
          win_d   = rr_idx[PTR_W-1:0];
          gnt_d   = rr_gnt;
          busy_d  = 1'b1;
        end
      end

      StLatch: begin
        // Operands are frozen here so a requester may drop req afterwards
        tipo_d  = tipo_i[win_q];
        monto_d = BAL_W'(monto_sel);
        gnt_d   = gnt_q;
        busy_d  = 1'b1;
        state_d = StExec;
      end

      StExec: begin
        gnt_d   = gnt_q;
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = StDone;
        if (bloqueo_in_i) begin
          flags_d[FLAG_RECHAZO] = 1'b1;
        end else if ((tipo_q == TIPO_RETIRO) && (monto_q > balance_q)) begin
          flags_d[FLAG_FONDOS] = 1'b1;
        end else if ((tipo_q == TIPO_DEPOSITO) && suma[BAL_W]) begin
          flags_d[FLAG_DESBORDE] = 1'b1;
        end else begin
          flags_d[FLAG_OK] = 1'b1;
          balance_d = (tipo_q == TIPO_RETIRO) ? (balance_q - monto_q) : suma[BAL_W-1:0];
        end
      end

      StDone: begin
        state_d = StIdle;
        if (win_q == PTR_W'(N_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_q + 1'b1;
        end
      end

      default: begin
        // Illegal encoding: fall back to IDLE without touching the balance
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      tipo_q    <= TIPO_DEPOSITO;
      monto_q   <= '0;
      balance_q <= BAL_INIT;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      tipo_q    <= tipo_d;
      monto_q   <= monto_d;
      balance_q <= balance_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      flags_q   <= flags_d;
    end
  end

  assign gnt_o                  = gnt_q;
  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign ok_o                   = flags_q[FLAG_OK];
  assign fondos_insuficientes_o = flags_q[FLAG_FONDOS];
  assign desborde_o             = flags_q[FLAG_DESBORDE];
  assign rechazado_o            = flags_q[FLAG_RECHAZO];
  assign balance_o              = balance_q;

endmodule

// File: tb/tb_arbitro_balance.sv
// Directed bench for arbitro_balance with a scoreboard of expected completions.
module tb_arbitro_balance;

  localparam int unsigned N  = 3;
  localparam int unsigned BW = 32;

  typedef struct packed {
    logic [2:0]  g;   // expected grant
    logic [3:0]  f;   // {rechazado, desborde, fondos, ok}
    logic [31:0] b;   // expected balance at done
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  tipo;
  logic [N*BW-1:0] monto;
  logic          bloqueo;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          done;
  logic          ok;
  logic          fondos;
  logic          desb;
  logic          rech;
  logic [BW-1:0] balance;

  exp_t        exp_q[$];
  logic [31:0] bal_m;
  int          n_cmp;
  int          n_err;

  arbitro_balance #(
    .N_REQ    (N),
    .BAL_W    (BW),
    .MONTO_W  (BW),
    .BAL_INIT (32'd100)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .req_i                  (req),
    .tipo_i                 (tipo),
    .monto_i                (monto),
    .bloqueo_in_i           (bloqueo),
    .gnt_o                  (gnt),
    .busy_o                 (busy),
    .done_o                 (done),
    .ok_o                   (ok),
    .fondos_insuficientes_o (fondos),
    .desborde_o             (desb),
    .rechazado_o            (rech),
    .balance_o              (balance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req_v);
    n_cmp++;
    assert (obs === req_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req_v);
    end
  endtask

  // Reference model for one transaction; pushes the expected completion
  task automatic push_exp(input int r, input bit t, input logic [31:0] m, input bit bl);
    exp_t        e;
    logic [32:0] s;
    e.g = 3'(1 << r);
    s   = {1'b0, bal_m} + {1'b0, m};
    if (bl)                  e.f = 4'b1000;
    else if (t && m > bal_m) e.f = 4'b0010;
    else if (!t && s[32])    e.f = 4'b0100;
    else begin
      e.f   = 4'b0001;
      bal_m = t ? (bal_m - m) : s[31:0];
    end
    e.b = bal_m;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_done"}, 64'(done), 64'(1'b1));
      chk({tag, "_gnt"}, 64'(gnt), 64'(e.g));
      chk({tag, "_flags"}, 64'({rech, desb, fondos, ok}), 64'(e.f));
      chk({tag, "_bal"}, 64'(balance), 64'(e.b));
    end
  endtask

  // Called at a negedge with the FSM in IDLE; returns at the following IDLE negedge
  task automatic run_txn(input string tag, input int r, input bit t, input logic [31:0] m,
                         input bit bl_latch, input bit bl_exec);
    push_exp(r, t, m, bl_exec);
    req[r] = 1'b1;
    tipo[r] = t;
    monto[r*BW +: BW] = m;
    @(negedge clk);  // LATCH
    chk({tag, "_gnt1"}, 64'(gnt), 64'(1 << r));
    chk({tag, "_busy1"}, 64'(busy), 64'(1'b1));
    req[r] = 1'b0;
    bloqueo = bl_latch;
    @(negedge clk);  // EXEC
    chk({tag, "_gnt2"}, 64'(gnt), 64'(1 << r));
    chk({tag, "_done2"}, 64'(done), 64'(1'b0));
    bloqueo = bl_exec;
    @(negedge clk);  // DONE
    pop_check(tag);
    bloqueo = 1'b0;
    @(negedge clk);  // IDLE
    chk({tag, "_idle"}, 64'({gnt, busy, done, rech, desb, fondos, ok}), 64'(0));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    req     = '0;
    tipo    = '0;
    monto   = '0;
    bloqueo = 1'b0;
    bal_m   = 32'd100;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", 64'({gnt, busy, done, rech, desb, fondos, ok}), 64'(0));
    chk("rst_bal", 64'(balance), 64'd100);
    rst_n = 1'b1;

    run_txn("dep50", 0, 1'b0, 32'd50, 1'b0, 1'b0);
    chk("dep50_abs", 64'(balance), 64'd150);
    run_txn("ret200", 1, 1'b1, 32'd200, 1'b0, 1'b0);
    chk("ret200_abs", 64'(balance), 64'd150);
    run_txn("ret150", 1, 1'b1, 32'd150, 1'b0, 1'b0);
    chk("ret150_abs", 64'(balance), 64'd0);
    run_txn("ret0", 2, 1'b1, 32'd0, 1'b0, 1'b0);
    run_txn("dep_big", 2, 1'b0, 32'hFFFF_FFF0, 1'b0, 1'b0);
    run_txn("dep_ovf", 0, 1'b0, 32'h20, 1'b0, 1'b0);
    chk("dep_ovf_abs", 64'(balance), 64'hFFFF_FFF0);
    run_txn("dep_max", 0, 1'b0, 32'hF, 1'b0, 1'b0);
    chk("dep_max_abs", 64'(balance), 64'hFFFF_FFFF);
    run_txn("bloq_exec", 2, 1'b1, 32'd10, 1'b0, 1'b1);
    chk("bloq_exec_abs", 64'(balance), 64'hFFFF_FFFF);
    run_txn("bloq_latch", 1, 1'b1, 32'd10, 1'b1, 1'b0);
    chk("bloq_latch_abs", 64'(balance), 64'hFFFF_FFF5);

    // Reset during EXEC of a deposit on req[1]; pointer is 2 at this point
    req[1] = 1'b1;
    tipo[1] = 1'b0;
    monto[1*BW +: BW] = 32'd5;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'({gnt, busy}), 64'({3'b010, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({gnt, busy, done, rech, desb, fondos, ok}), 64'(0));
    chk("mid_rst_bal", 64'(balance), 64'd100);
    bal_m = 32'd100;
    req   = 3'b111;
    tipo  = 3'b000;
    for (int i = 0; i < N; i++) monto[i*BW +: BW] = 32'd1;
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters held: rotation 001, 010, 100, 001 with one IDLE gap each
    for (int g = 0; g < 4; g++) begin
      push_exp(g % 3, 1'b0, 32'd1, 1'b0);
      @(negedge clk);
      chk($sformatf("rr%0d_gnt1", g), 64'(gnt), 64'(1 << (g % 3)));
      @(negedge clk);
      chk($sformatf("rr%0d_gnt2", g), 64'(gnt), 64'(1 << (g % 3)));
      @(negedge clk);
      pop_check($sformatf("rr%0d", g));
      if (g == 3) req = '0;
      @(negedge clk);
      chk($sformatf("rr%0d_gap", g), 64'({gnt, busy}), 64'(0));
    end
    chk("rr_bal", 64'(balance), 64'd104);
    chk("sb_drain", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
